sharp_mlcd_multiline_writer: RTL

Parametrised successor to the single-line Sharp memory-LCD driver. Drives LS013B7DH01-class panels over a 3-wire SPI-like link (SCS, SCLK, SI). Supports multi-line burst update, all-clear and static (display-maintain) commands, and a selectable VCOM scheme. Line pixel data is fetched on demand from an upstream frame store through a request/valid handshake, and a simple start/busy/done interface lets a top-level controller sequence frames.

---
 rtl/sharp_mlcd_multiline_writer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sharp_mlcd_multiline_writer.sv
// Sharp memory-LCD writer: multi-line update, all-clear and static commands over the
// 3-wire SCS/SCLK/SI link, with line pixels pulled on demand from a frame store.
module sharp_mlcd_multiline_writer #(
  parameter int unsigned PIXELS_PER_LINE = 144,
  parameter int unsigned NUM_LINES       = 168,
  parameter int unsigned SCLK_HALF       = 6,
  parameter int unsigned TS_SCS          = 8,
  parameter int unsigned TH_SCS          = 8,
  parameter int unsigned T_GAP           = 12,
  parameter int unsigned VCOM_HW         = 1,
  parameter int unsigned VCOM_DIV        = 100000
) (
  input  logic                       clk_12mhz,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [1:0]                 cmd,
  input  logic [7:0]                 first_line,
  input  logic [7:0]                 line_count,
  output logic                       line_req,
  output logic [7:0]                 line_addr,
  input  logic [PIXELS_PER_LINE-1:0] line_data,
  input  logic                       line_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       SCS,
  output logic                       SCLK,
  output logic                       SI,
  output logic                       EXTCOMIN
);

  localparam int unsigned BIT_CYC   = 2 * SCLK_HALF;
  localparam int unsigned PW        = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  // MODE's first half-bit already counts toward TS_SCS
  localparam int unsigned SETUP_CYC = (TS_SCS > SCLK_HALF) ? (TS_SCS - SCLK_HALF) : 1;
  localparam int unsigned CMAX_A    = (PIXELS_PER_LINE > T_GAP) ? PIXELS_PER_LINE : T_GAP;
  localparam int unsigned CMAX_B    = (TH_SCS > SETUP_CYC) ? TH_SCS : SETUP_CYC;
  localparam int unsigned CMAX      = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int unsigned CW        = $clog2(CMAX + 1);
  localparam int unsigned VW        = $clog2(VCOM_DIV + 1);

  localparam logic [1:0] CMD_UPD = 2'b00;
  localparam logic [1:0] CMD_CLR = 2'b01;
  localparam logic [1:0] CMD_RSV = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_MODE, S_FETCH, S_ADDR, S_DATA, S_LDUMMY, S_TAIL, S_HOLD, S_GAP
  } state_e;

  state_e                     state_q;
  logic [PW-1:0]              ph_q;
  logic [CW-1:0]              cnt_q;
  logic [7:0]                 byte_q;
  logic [PIXELS_PER_LINE-1:0] lbuf_q;
  logic [1:0]                 cmd_q;
  logic [7:0]                 addr_q;
  logic [7:0]                 lines_q;
  logic                       scs_q, sclk_q, si_q, busy_q, done_q, err_q, req_q;
  logic [VW-1:0]              vcnt_q;
  logic                       vcom_q;

  logic                       start_bad_c;
  logic [7:0]                 mode_c;
  logic [7:0]                 addr_next_c;

  assign start_bad_c = (cmd == CMD_RSV) ||
                       ((cmd == CMD_UPD) && ((first_line == 8'd0) ||
                                             (32'(first_line) > NUM_LINES) ||
                                             (line_count == 8'd0)));
  assign mode_c      = {5'b0, cmd_q == CMD_CLR, (VCOM_HW != 0) ? 1'b0 : vcom_q, cmd_q == CMD_UPD};
  assign addr_next_c = (addr_q == 8'(NUM_LINES)) ? 8'd1 : addr_q + 8'd1;

  // Free-running VCOM divider, independent of the transfer FSM
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      vcnt_q <= '0;
      vcom_q <= 1'b0;
    end else if (vcnt_q == VW'(VCOM_DIV - 1)) begin
      vcnt_q <= '0;
      vcom_q <= ~vcom_q;
    end else begin
      vcnt_q <= vcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      lbuf_q  <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      lines_q <= '0;
      scs_q   <= 1'b0;
      sclk_q  <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && start_bad_c) begin
            err_q <= 1'b1;
          end else if (start) begin
            cmd_q   <= cmd;
            addr_q  <= first_line;
            lines_q <= line_count;
            scs_q   <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(SETUP_CYC - 1);
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_MODE;
            ph_q    <= '0;
            cnt_q   <= CW'(7);
            si_q    <= mode_c[0];
            byte_q  <= {1'b0, mode_c[7:1]};
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FETCH: begin
          if (req_q && line_valid) begin
            req_q   <= 1'b0;
            lbuf_q  <= line_data;
            state_q <= S_ADDR;
            ph_q    <= '0;
            cnt_q   <= CW'(7);
            si_q    <= addr_q[0];
            byte_q  <= {1'b0, addr_q[7:1]};
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            scs_q   <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= CW'(T_GAP - 1);
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          // Serial field states: SCLK low then high within each bit, SI changes on the fall
          if (ph_q == PW'(SCLK_HALF - 1)) begin
            sclk_q <= 1'b1;
            ph_q   <= ph_q + 1'b1;
          end else if (ph_q == PW'(BIT_CYC - 1)) begin
            sclk_q <= 1'b0;
            ph_q   <= '0;
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
              if (state_q == S_DATA) begin
                si_q   <= lbuf_q[0];
                lbuf_q <= lbuf_q >> 1;
              end else begin
                si_q   <= byte_q[0];
                byte_q <= byte_q >> 1;
              end
            end else begin
              si_q   <= 1'b0;
              byte_q <= '0;
              cnt_q  <= CW'(7);
              case (state_q)
                S_MODE: begin
                  if (cmd_q == CMD_UPD) begin
                    req_q   <= 1'b1;
                    state_q <= S_FETCH;
                  end else begin
                    state_q <= S_TAIL;
                  end
                end
                S_ADDR: begin
                  si_q    <= lbuf_q[0];
                  lbuf_q  <= lbuf_q >> 1;
                  cnt_q   <= CW'(PIXELS_PER_LINE - 1);
                  state_q <= S_DATA;
                end
                S_DATA: state_q <= S_LDUMMY;
                S_LDUMMY: begin
                  if (lines_q == 8'd1) begin
                    state_q <= S_TAIL;
                  end else begin
                    lines_q <= lines_q - 8'd1;
                    addr_q  <= addr_next_c;
                    req_q   <= 1'b1;
                    state_q <= S_FETCH;
                  end
                end
                default: begin
                  cnt_q   <= CW'(TH_SCS - 1);
                  state_q <= S_HOLD;
                end
              endcase
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign line_req  = req_q;
  assign line_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign SCS       = scs_q;
  assign SCLK      = sclk_q;
  assign SI        = si_q;
  assign EXTCOMIN  = (VCOM_HW != 0) ? vcom_q : 1'b0;

endmodule
